// File: rtl/usb_sched_pkg.sv
// usb_sched_pkg: shared types for the USB frame scheduler (state encoding, frame number)
package usb_sched_pkg;
  localparam int FRAME_NUM_W = 11;
  typedef logic [FRAME_NUM_W-1:0] frame_num_t;
  typedef enum logic [2:0] {HALT, SOF, ARB, BUSY, EOF} state_t;
endpackage

// File: rtl/usb_frame_scheduler_if.sv
// usb_frame_scheduler_if: scheduler handshake bundle
//   master: requesters + transmitter side (drives enable, req, done, sof_done)
//   slave:  scheduler side (drives gnt, sof_start, frame_num, frame_overrun)
interface usb_frame_scheduler_if #(parameter int N = 4);
  import usb_sched_pkg::*;
  logic enable;
  logic [N-1:0] req;
  logic [N-1:0] gnt;
  logic done;
  logic sof_start;
  logic sof_done;
  frame_num_t frame_num;
  logic frame_overrun;
  modport master (output enable, req, done, sof_done, input gnt, sof_start, frame_num, frame_overrun);
  modport slave (input enable, req, done, sof_done, output gnt, sof_start, frame_num, frame_overrun);
endinterface

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first requester after ptr
//   req: request vector, ptr: last granted index
//   gnt: one-hot pick, idx: picked index, any: at least one request
module rr_arbiter #(parameter int N = 4) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] idx,
  output logic                 any
);
  localparam int IW = $clog2(N);
  logic [IW-1:0] c;
  assign any = |req;
  // Scan from farthest to nearest so the nearest requester after ptr wins.
  always_comb begin
    idx = ptr;
    c = '0;
    for (int k = N; k >= 1; k--) begin
      c = IW'((int'(ptr) + k) % N);
      if (req[c]) idx = c;
    end
  end
  always_comb begin
    gnt = '0;
    gnt[idx] = any;
  end
endmodule

// File: rtl/usb_frame_scheduler.sv
// usb_frame_scheduler: 1 ms SOF generation plus round-robin transmitter grants between SOFs
//   clk, reset (async, active-high)
//   bus (slave): enable, req, done, sof_done in; gnt, sof_start, frame_num, frame_overrun out
module usb_frame_scheduler
  import usb_sched_pkg::*;
#(
  parameter int N = 4,
  parameter int FRAME_CYCLES = 24000,
  parameter int GUARD_CYCLES = 2400
) (
  input logic clk,
  input logic reset,
  usb_frame_scheduler_if.slave bus
);
  localparam int IW = $clog2(N);
  localparam int CW = $clog2(FRAME_CYCLES);
  state_t state;
  logic [CW-1:0] cnt;
  logic [IW-1:0] ptr;
  logic [N-1:0] gnt;
  logic [N-1:0] pick;
  logic [IW-1:0] pick_idx;
  logic any;
  logic late;
  logic sof_start;
  logic frame_overrun;
  frame_num_t frame_num;
  logic wrap;
  logic guard;
  assign wrap = state != HALT && cnt == CW'(FRAME_CYCLES - 1);
  assign guard = cnt >= CW'(FRAME_CYCLES - GUARD_CYCLES);
  rr_arbiter #(.N(N)) u_arb (
    .req(bus.req),
    .ptr(ptr),
    .gnt(pick),
    .idx(pick_idx),
    .any(any)
  );
  // late marks a frame boundary passed during BUSY: the SOF is owed as soon as done arrives.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= HALT;
      cnt <= '0;
      ptr <= IW'(N - 1);
      gnt <= '0;
      late <= 1'b0;
      sof_start <= 1'b0;
      frame_overrun <= 1'b0;
      frame_num <= '0;
    end else begin
      sof_start <= 1'b0;
      frame_overrun <= 1'b0;
      cnt <= (state == HALT || wrap) ? '0 : cnt + 1'b1;
      case (state)
        HALT: if (bus.enable) begin
          state <= SOF;
          sof_start <= 1'b1;
        end
        SOF: if (bus.sof_done) begin
          frame_num <= frame_num + 1'b1;
          if (!bus.enable) begin
            state <= HALT;
            cnt <= '0;
          end else if (wrap) sof_start <= 1'b1;
          else state <= ARB;
        end else if (wrap) frame_overrun <= 1'b1;
        ARB: if (!bus.enable) begin
          state <= HALT;
          cnt <= '0;
        end else if (wrap) begin
          state <= SOF;
          sof_start <= 1'b1;
        end else if (guard) state <= EOF;
        else if (any) begin
          gnt <= pick;
          ptr <= pick_idx;
          state <= BUSY;
        end
        BUSY: begin
          if (wrap) frame_overrun <= 1'b1;
          if (bus.done) begin
            gnt <= '0;
            late <= 1'b0;
            if (!bus.enable) begin
              state <= HALT;
              cnt <= '0;
            end else if (late || wrap) begin
              state <= SOF;
              sof_start <= 1'b1;
            end else state <= ARB;
          end else if (wrap) late <= 1'b1;
        end
        EOF: if (!bus.enable) begin
          state <= HALT;
          cnt <= '0;
        end else if (wrap) begin
          state <= SOF;
          sof_start <= 1'b1;
        end
        default: state <= HALT;
      endcase
    end
  end
  assign bus.gnt = gnt;
  assign bus.sof_start = sof_start;
  assign bus.frame_num = frame_num;
  assign bus.frame_overrun = frame_overrun;
endmodule

// File: tb/tb_usb_frame_scheduler.sv
// tb_usb_frame_scheduler: directed + randomized bench with a flag-based behavioural model
module tb_usb_frame_scheduler;
  localparam int N = 4;
  localparam int FC = 200;
  localparam int GC = 40;
  localparam int FCB = 16;
  localparam int GCB = 4;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic rst_b = 1'b0;
  int cyc = 0;
  int passed = 0;
  int total = 0;
  bit chk_on = 1'b1;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  usb_frame_scheduler_if #(.N(N)) bus_a ();
  usb_frame_scheduler_if #(.N(N)) bus_b ();
  usb_frame_scheduler #(.N(N), .FRAME_CYCLES(FC), .GUARD_CYCLES(GC)) dut_a (
    .clk(clk), .reset(rst), .bus(bus_a)
  );
  usb_frame_scheduler #(.N(N), .FRAME_CYCLES(FCB), .GUARD_CYCLES(GCB)) dut_b (
    .clk(clk), .reset(rst_b), .bus(bus_b)
  );
  function automatic void check(string name, longint act, longint exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endfunction
  // Model: running / awaiting-SOF-ack / owner-of-transmitter flags plus frame time.
  bit m_run, m_sofw, m_late, e_sof, e_ovr;
  int m_owner, m_cnt, m_ptr, m_fn;
  logic [N-1:0] e_gnt;
  function automatic void model_reset();
    m_run = 0; m_sofw = 0; m_late = 0; m_owner = -1; m_cnt = 0;
    m_ptr = N - 1; m_fn = 0; e_gnt = '0; e_sof = 0; e_ovr = 0;
  endfunction
  function automatic void model_step(bit en, logic [N-1:0] rq, bit dn, bit sd);
    bit wrap;
    int ncnt;
    wrap = m_run && m_cnt == FC - 1;
    ncnt = (!m_run || wrap) ? 0 : m_cnt + 1;
    e_sof = 0;
    e_ovr = 0;
    if (!m_run) begin
      if (en) begin m_run = 1; m_sofw = 1; e_sof = 1; end
    end else if (m_sofw) begin
      if (sd) begin
        m_fn = (m_fn + 1) % 2048;
        if (!en) begin m_run = 0; m_sofw = 0; ncnt = 0; end
        else if (wrap) e_sof = 1;
        else m_sofw = 0;
      end else if (wrap) e_ovr = 1;
    end else if (m_owner >= 0) begin
      if (wrap) e_ovr = 1;
      if (dn) begin
        m_owner = -1;
        if (!en) begin m_run = 0; ncnt = 0; end
        else if (m_late || wrap) begin m_sofw = 1; e_sof = 1; end
        m_late = 0;
      end else if (wrap) m_late = 1;
    end else begin
      if (!en) begin m_run = 0; ncnt = 0; end
      else if (wrap) begin m_sofw = 1; e_sof = 1; end
      else if (m_cnt < FC - GC)
        for (int k = 1; k <= N; k++)
          if (m_owner < 0 && rq[(m_ptr + k) % N]) begin m_owner = (m_ptr + k) % N; m_ptr = m_owner; end
    end
    m_cnt = ncnt;
    e_gnt = '0;
    if (m_owner >= 0) e_gnt[m_owner] = 1'b1;
  endfunction
  initial begin
    model_reset();
    forever begin
      @(posedge clk);
      if (rst) model_reset();
      else model_step(bus_a.enable, bus_a.req, bus_a.done, bus_a.sof_done);
      @(negedge clk);
      if (chk_on) begin
        check("model_gnt", bus_a.gnt, e_gnt);
        check("model_sof_start", bus_a.sof_start, e_sof);
        check("model_frame_num", bus_a.frame_num, m_fn);
        check("model_frame_overrun", bus_a.frame_overrun, e_ovr);
      end
    end
  end
  task automatic wait_gnt(input int lim, output bit ok);
    ok = 0;
    for (int i = 0; i < lim; i++) begin
      @(negedge clk);
      if (bus_a.gnt != 0) begin ok = 1; break; end
    end
  endtask
  task automatic wait_sof(input int lim, output bit ok);
    ok = 0;
    for (int i = 0; i < lim; i++) begin
      @(negedge clk);
      if (bus_a.sof_start) begin ok = 1; break; end
    end
  endtask
  task automatic pulse_done();
    bus_a.done = 1; @(negedge clk); bus_a.done = 0;
  endtask
  task automatic pulse_sof_done();
    bus_a.sof_done = 1; @(negedge clk); bus_a.sof_done = 0;
  endtask
  task automatic main_seq();
    bit ok, saw;
    int t_sof, t_done, t_ovr, n_ovr, n_sof, fn0;
    logic [N-1:0] rr_exp [5];
    rr_exp[0] = 4'b0001; rr_exp[1] = 4'b0010; rr_exp[2] = 4'b0100; rr_exp[3] = 4'b1000; rr_exp[4] = 4'b0001;
    bus_a.enable = 0; bus_a.req = '0; bus_a.done = 0; bus_a.sof_done = 0;
    #1 rst = 1;
    repeat (3) @(negedge clk);
    check("rst_gnt", bus_a.gnt, 0);
    check("rst_sof_start", bus_a.sof_start, 0);
    check("rst_frame_num", bus_a.frame_num, 0);
    check("rst_overrun", bus_a.frame_overrun, 0);
    rst = 0;
    repeat (2) @(negedge clk);
    check("halt_no_sof", bus_a.sof_start, 0);
    bus_a.enable = 1;
    @(negedge clk);
    check("first_sof", bus_a.sof_start, 1);
    check("first_sof_fn", bus_a.frame_num, 0);
    t_sof = cyc;
    repeat (10) @(negedge clk);
    pulse_sof_done();
    check("fn_after_sof_done", bus_a.frame_num, 1);
    bus_a.req = 4'b1111;
    t_done = 0;
    for (int i = 0; i < 5; i++) begin
      wait_gnt(30, ok);
      check("rr_gnt_seen", ok, 1);
      check("rr_gnt", bus_a.gnt, rr_exp[i]);
      if (i > 0) check("rr_latency", cyc - t_done, 2);
      if (i == 4) bus_a.req = '0;
      repeat (5) @(negedge clk);
      t_done = cyc;
      pulse_done();
    end
    wait_sof(250, ok);
    check("sof2_seen", ok, 1);
    check("sof_period", cyc - t_sof, FC);
    t_sof = cyc;
    repeat (3) @(negedge clk);
    pulse_sof_done();
    while (cyc - t_sof < 165) @(negedge clk);
    bus_a.req = 4'b0100;
    saw = 0; ok = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (bus_a.gnt != 0) saw = 1;
      if (bus_a.sof_start) begin ok = 1; break; end
    end
    check("guard_no_gnt", saw, 0);
    check("guard_sof_seen", ok, 1);
    check("guard_sof_time", cyc - t_sof, FC);
    t_sof = cyc;
    repeat (3) @(negedge clk);
    t_done = cyc;
    pulse_sof_done();
    wait_gnt(10, ok);
    check("guard_gnt_seen", ok, 1);
    check("guard_gnt_latency", cyc - t_done, 2);
    check("guard_gnt", bus_a.gnt, 4'b0100);
    bus_a.req = '0;
    repeat (2) @(negedge clk);
    pulse_done();
    while (cyc - t_sof < 149) @(negedge clk);
    bus_a.req = 4'b0010;
    wait_gnt(5, ok);
    check("ovr_gnt_seen", ok, 1);
    check("ovr_gnt_counter", cyc - t_sof, 150);
    bus_a.req = '0;
    fn0 = int'(bus_a.frame_num);
    n_ovr = 0; n_sof = 0; t_ovr = 0;
    while (cyc - t_sof < 220) begin
      @(negedge clk);
      if (bus_a.frame_overrun) begin n_ovr++; t_ovr = cyc; end
      if (bus_a.sof_start) n_sof++;
    end
    check("ovr_pulses", n_ovr, 1);
    check("ovr_at_wrap", t_ovr - t_sof, FC);
    check("ovr_no_sof_before_done", n_sof, 0);
    check("ovr_gnt_held", bus_a.gnt, 4'b0010);
    pulse_done();
    check("ovr_sof_after_done", bus_a.sof_start, 1);
    check("ovr_fn_held", bus_a.frame_num, fn0);
    repeat (2) @(negedge clk);
    pulse_sof_done();
    check("ovr_fn_inc", bus_a.frame_num, (fn0 + 1) % 2048);
    wait_sof(250, ok);
    check("ovr_next_sof_seen", ok, 1);
    check("ovr_next_sof_time", cyc - t_sof, 2 * FC);
    check("ovr_fn_once", bus_a.frame_num, (fn0 + 1) % 2048);
    pulse_sof_done();
    for (int seg = 0; seg < 6; seg++) begin
      int pd;
      pd = (seg % 3 == 0) ? 2 : (seg % 3 == 1) ? 40 : 300;
      repeat (600) begin
        @(negedge clk);
        bus_a.enable = $urandom_range(0, 199) != 0;
        bus_a.req = N'($urandom_range(0, 15));
        bus_a.done = (bus_a.gnt != 0) ? ($urandom_range(1, pd) == 1) : ($urandom_range(0, 19) == 0);
        bus_a.sof_done = $urandom_range(1, pd) == 1;
      end
    end
    bus_a.enable = 1; bus_a.done = 0; bus_a.sof_done = 0;
    ok = 0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      bus_a.req = 4'b0001;
      bus_a.sof_done = 1;
      if (bus_a.gnt != 0) begin ok = 1; break; end
    end
    check("busy_reached", ok, 1);
    bus_a.sof_done = 0;
    bus_a.req = '0;
    #2 rst = 1;
    #1;
    check("async_rst_gnt", bus_a.gnt, 0);
    check("async_rst_sof_start", bus_a.sof_start, 0);
    check("async_rst_overrun", bus_a.frame_overrun, 0);
    check("async_rst_frame_num", bus_a.frame_num, 0);
    repeat (2) @(negedge clk);
    rst = 0;
    @(negedge clk);
    check("post_rst_sof", bus_a.sof_start, 1);
    check("post_rst_fn", bus_a.frame_num, 0);
    repeat (5) @(negedge clk);
    chk_on = 0;
  endtask
  task automatic wrap_seq();
    bit ok;
    bus_b.enable = 0; bus_b.req = '0; bus_b.done = 0; bus_b.sof_done = 0;
    #1 rst_b = 1;
    repeat (2) @(negedge clk);
    rst_b = 0;
    bus_b.enable = 1;
    for (int i = 0; i <= 2048; i++) begin
      ok = 0;
      for (int w = 0; w < 4 * FCB; w++) begin
        @(negedge clk);
        if (bus_b.sof_start) begin ok = 1; break; end
      end
      if (!ok) begin check("wrap_sof_seen", ok, 1); break; end
      check("wrap_frame_num", bus_b.frame_num, i % 2048);
      bus_b.sof_done = 1; @(negedge clk); bus_b.sof_done = 0;
    end
    check("wrap_fn_after_2049", bus_b.frame_num, 1);
  endtask
  initial begin
    #1_500_000;
    $display("FAIL watchdog: bench stuck at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end
  initial begin
    fork
      main_seq();
      wrap_seq();
    join
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
